mux8_rr_arbiter: RTL and testbench
==================================

# mux8_rr_arbiter

Round-robin arbiter that shares the 8-way, 8-bit select multiplexer between eight requesters, such as interrupt sources or peripheral data ports. It samples a request vector and grants exactly one requester at a time, then drives the multiplexer's 3-bit select with the winner's index. The grant is held until the owner releases it, drops its request, or exceeds a hold limit. Every ownership change passes through a one-cycle dead slot, so a consumer never sees two owners' data in back-to-back cycles.

## Interface
- MAX_HOLD, default 16: maximum cycles a single grant may last before a forced release; legal range 2..255.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit i set means requester i wants the multiplexer.
- rel  input  1  voluntary release strobe from the current owner; ignored in IDLE.
- lock  input  1  while high during GRANT, the hold-limit timeout is suppressed.
- sel  output  3  multiplexer select (index of current or most recent owner).
- gnt  output  8  one-hot grant, all-zero when no owner.
- busy  output  1  high while in GRANT.
- timeout  output  1  one-cycle pulse when a grant is forcibly ended by the hold limit.

## Operation
- Two states:
  - IDLE: gnt=0, busy=0.
  - GRANT: gnt=onehot(sel), busy=1.
- Priority pointer ptr (3 bits):
  - Winner search order is ptr, ptr+1, …, ptr+7, modulo 8.
  - On every grant end, ptr = sel+1 (mod 8; wraps 7→0).
- Hold counter hcnt (8 bits):
  - Cleared on grant start.
  - Increments each GRANT cycle, saturating at MAX_HOLD-1.
- IDLE → GRANT: if req≠0, sel := first set bit in search order, hcnt := 0.
- GRANT → IDLE, evaluated in priority order:
  1. rel=1 or req[sel]=0: voluntary end, timeout stays 0.
  2. Otherwise, if lock=0 and hcnt=MAX_HOLD-1: forced end, timeout=1 in the following cycle.
- lock=1 with hcnt saturated: the grant continues indefinitely. The timeout fires on the first cycle lock falls, provided no voluntary end occurs in that cycle.
- sel is held unchanged in IDLE, so the multiplexer output stays stable.
- req bits of non-owners have no effect during GRANT.
- rel is ignored in IDLE.

## Timing
- Reset values, applied at the first rising edge with rst=1: state=IDLE, sel=0, gnt=0, busy=0, timeout=0, ptr=0, hcnt=0.
- Reset has priority over all other inputs, including mid-grant.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Grant latency:
  - A req sampled in IDLE at edge n gives gnt/sel/busy valid after edge n.
  - Release sampled at edge m gives gnt=0 after edge m, with one IDLE cycle minimum.
  - The next grant appears after edge m+1.
- Maximum unlocked grant length is MAX_HOLD cycles of gnt high.
- timeout is high for exactly the single IDLE cycle following a forced end.
- rel and the hold limit in the same cycle: the voluntary end wins and timeout=0.
- The owner's req drop and rel in the same cycle count as one normal release.
- A single requester with continuous req is re-granted after each dead cycle: pattern of MAX_HOLD cycles granted, then 1 cycle idle.

## Test plan
- Reset and single request:
  - Stimulus: rst for 2 cycles, then req=8'h08.
  - Required: sel=3 and gnt=8'h08 one cycle later.
  - Then rel pulse → gnt=0 for 1 cycle; re-grant to 3 next cycle, since req is still high.
- Round-robin fairness:
  - Stimulus: req=8'hFF held, each owner pulses rel on its 2nd grant cycle.
  - Required: grant order 0,1,2,…,7,0, each grant separated by one idle cycle.
- Pointer wrap:
  - Stimulus: grant to 7 ends, with req=8'h81.
  - Required: next grant goes to 0; the following grant goes to 7.
- Hold-limit timeout with MAX_HOLD=4:
  - Stimulus: req=8'h04 held, rel=0.
  - Required: gnt=8'h04 for 4 cycles, then gnt=0 with timeout=1 for 1 cycle; the same pattern repeats.
- Lock and collision:
  - Stimulus: MAX_HOLD=4, lock=1 for 10 cycles, then lock=0 in the same cycle as rel=1.
  - Required: gnt held for 10+ cycles; end with timeout=0.
- Reset mid-grant:
  - Stimulus: rst asserted while busy=1 and sel=5.
  - Required: after the edge, sel=0, gnt=0, busy=0, ptr=0; the next req=8'h21 grants 0.

Source files
------------

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for eight requesters sharing an 8:1 mux. It holds a grant until the
// owner releases it or the hold limit expires, and inserts one idle cycle between owners.
module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       rel,
  input  logic       lock,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [7:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;

  logic [2:0] win;
  logic       win_vld;
  logic [2:0] idx;

  // Scan from the farthest offset down so the entry closest to ptr is written last and wins.
  always_comb begin
    win     = ptr_q;
    win_vld = 1'b0;
    idx     = '0;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr_q + 3'(i);
      if (req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    hcnt_d    = hcnt_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_vld) begin
          state_d = StGrant;
          sel_d   = win;
          hcnt_d  = '0;
          gnt_d   = 8'(1) << win;
          busy_d  = 1'b1;
        end
      end
      StGrant: begin
        // A voluntary end takes priority over the hold limit and never flags a timeout.
        if (rel || !req[sel_q]) begin
          state_d = StIdle;
          ptr_d   = sel_q + 3'd1;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else if (!lock && (hcnt_q == HoldLast)) begin
          state_d   = StIdle;
          ptr_d     = sel_q + 3'd1;
          gnt_d     = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end else if (hcnt_q != HoldLast) begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      ptr_q     <= '0;
      hcnt_q    <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      hcnt_q    <= hcnt_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign sel     = sel_q;
  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: directed scenarios plus random traffic, every cycle compared
// against an ownership-level reference model.
module tb_mux8_rr_arbiter;

  localparam int MH = 4;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       rel;
  logic       lock;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       busy;
  logic       timeout;

  int n_total;
  int n_bad;

  // Reference model: who owns the mux, how many edges it has held it, where the search starts.
  int m_owner;
  int m_sel;
  int m_ptr;
  int m_cnt;
  bit m_tout;

  mux8_rr_arbiter #(
    .MAX_HOLD(MH)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .rel    (rel),
    .lock   (lock),
    .sel    (sel),
    .gnt    (gnt),
    .busy   (busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic [7:0] q, input logic rl, input logic lk);
    if (r) begin
      m_owner = -1;
      m_sel   = 0;
      m_ptr   = 0;
      m_cnt   = 0;
      m_tout  = 0;
    end else begin
      m_tout = 0;
      if (m_owner < 0) begin
        for (int i = 0; i < 8; i++) begin
          int c;
          c = (m_ptr + i) % 8;
          if (q[c] && m_owner < 0) begin
            m_owner = c;
            m_sel   = c;
            m_cnt   = 0;
          end
        end
      end else if (rl || !q[m_owner]) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end else if (!lk && m_cnt >= MH - 1) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_tout  = 1;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic step(input logic r, input logic [7:0] q, input logic rl, input logic lk);
    logic [7:0] eg;
    rst  = r;
    req  = q;
    rel  = rl;
    lock = lk;
    @(posedge clk);
    model_edge(r, q, rl, lk);
    #1;
    eg = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
    check_eq("gnt", 32'(gnt), 32'(eg));
    check_eq("sel", 32'(sel), 32'(m_sel));
    check_eq("busy", 32'(busy), 32'(m_owner >= 0));
    check_eq("timeout", 32'(timeout), 32'(m_tout));
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    m_owner = -1;
    m_sel   = 0;
    m_ptr   = 0;
    m_cnt   = 0;
    m_tout  = 0;
    rst     = 1'b1;
    req     = '0;
    rel     = 1'b0;
    lock    = 1'b0;

    // Reset and single request
    step(1, 8'h00, 0, 0);
    step(1, 8'h00, 0, 0);
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    step(0, 8'h08, 0, 0);
    check_eq("single_sel", 32'(sel), 32'd3);
    check_eq("single_gnt", 32'(gnt), 32'h08);
    step(0, 8'h08, 1, 0);
    check_eq("rel_dead_gnt", 32'(gnt), 32'h0);
    step(0, 8'h08, 0, 0);
    check_eq("regrant_gnt", 32'(gnt), 32'h08);
    step(0, 8'h00, 0, 0);

    // Round-robin fairness, release on the 2nd grant cycle
    step(1, 8'h00, 0, 0);
    for (int k = 0; k < 9; k++) begin
      step(0, 8'hFF, 0, 0);
      check_eq("rr_sel", 32'(sel), 32'(k % 8));
      step(0, 8'hFF, 0, 0);
      step(0, 8'hFF, 1, 0);
      check_eq("rr_dead", 32'(busy), 32'h0);
    end

    // Pointer wrap from 7 to 0
    step(1, 8'h00, 0, 0);
    step(0, 8'h80, 0, 0);
    check_eq("wrap_sel7", 32'(sel), 32'd7);
    step(0, 8'h81, 1, 0);
    step(0, 8'h81, 0, 0);
    check_eq("wrap_sel0", 32'(sel), 32'd0);
    step(0, 8'h81, 1, 0);
    step(0, 8'h81, 0, 0);
    check_eq("wrap_back7", 32'(sel), 32'd7);

    // Hold-limit timeout, two rounds
    step(1, 8'h00, 0, 0);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < MH; c++) begin
        step(0, 8'h04, 0, 0);
        check_eq("hold_gnt", 32'(gnt), 32'h04);
      end
      step(0, 8'h04, 0, 0);
      check_eq("to_gnt", 32'(gnt), 32'h0);
      check_eq("to_pulse", 32'(timeout), 32'h1);
    end
    step(0, 8'h00, 0, 0);

    // Lock past the limit, then lock falls together with rel
    step(1, 8'h00, 0, 0);
    for (int c = 0; c < 11; c++) begin
      step(0, 8'h04, 0, 1);
      check_eq("lock_hold", 32'(gnt), 32'h04);
    end
    step(0, 8'h04, 1, 0);
    check_eq("lock_end_gnt", 32'(gnt), 32'h0);
    check_eq("lock_end_to", 32'(timeout), 32'h0);

    // Reset mid-grant
    step(1, 8'h00, 0, 0);
    step(0, 8'h20, 0, 0);
    check_eq("mid_sel5", 32'(sel), 32'd5);
    step(1, 8'h20, 0, 0);
    check_eq("mid_rst_sel", 32'(sel), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'h0);
    step(0, 8'h21, 0, 0);
    check_eq("mid_regrant", 32'(sel), 32'd0);

    // Random traffic
    begin
      logic [7:0] q;
      logic       lk;
      q  = '0;
      lk = 1'b0;
      for (int n = 0; n < 1500; n++) begin
        if ($urandom_range(0, 3) == 0) q = 8'($urandom) & 8'($urandom);
        if ($urandom_range(0, 7) == 0) lk = ~lk;
        step(($urandom_range(0, 99) == 0), q, ($urandom_range(0, 7) == 0), lk);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
